// File: rtl/eth_mii_tx_if.sv
// Frame-memory read port, start/done handshake and MII transmit pins of eth_mii_tx.
// The transmitter uses the slave modport; whoever owns the frame memory and the start request uses master.
interface eth_mii_tx_if;
    logic        start;
    logic [10:0] addr;
    logic [7:0]  din;
    logic [3:0]  tx_d;
    logic        tx_en;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output din,
        input  addr,
        input  tx_d,
        input  tx_en,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  din,
        output addr,
        output tx_d,
        output tx_en,
        output busy,
        output done
    );
endinterface

// File: rtl/eth_mii_tx.sv
// Ethernet MII transmit stage: reads a stored frame byte by byte, sends it as nibbles,
// appends the CRC-32 FCS and holds off for the inter-frame gap before signalling done.
module eth_mii_tx #(
    parameter int FRAME_LEN    = 1396,
    parameter int PREAMBLE_LEN = 8,
    parameter int IFG_CYCLES   = 24
) (
    input logic         clk,
    input logic         rst,
    eth_mii_tx_if.slave bus
);

    localparam logic [10:0]      LAST_BYTE = 11'(FRAME_LEN - 1);
    localparam logic [10:0]      FIRST_CRC = 11'(PREAMBLE_LEN);
    localparam int               IFG_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'(IFG_CYCLES - 1);
    localparam logic [31:0]      CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0]      CRC_POLY  = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DATA,
        FCS,
        IFG
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [10:0]      addr_q;
    logic [10:0]      addr_n;
    logic [10:0]      byte_idx;
    logic [10:0]      byte_idx_n;
    logic [10:0]      next_idx;
    logic             hi_phase;
    logic             hi_phase_n;
    logic [7:0]       shift_q;
    logic [7:0]       shift_n;
    logic [31:0]      crc_q;
    logic [31:0]      crc_n;
    logic [31:0]      fcs;
    logic [2:0]       nib_q;
    logic [2:0]       nib_n;
    logic [2:0]       nib_next;
    logic [IFG_W-1:0] ifg_q;
    logic [IFG_W-1:0] ifg_n;
    logic [3:0]       tx_d_q;
    logic [3:0]       tx_d_n;
    logic             tx_en_q;
    logic             tx_en_n;
    logic             busy_q;
    logic             busy_n;
    logic             done_q;
    logic             done_n;

    // Reflected CRC-32 advanced by one nibble, least-significant bit first.
    function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ CRC_POLY;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    assign fcs      = ~crc_q;
    assign next_idx = byte_idx + 11'd1;
    assign nib_next = nib_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The CRC absorbs each nibble as it is loaded into tx_d, so it is complete when the last one leaves.
    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        byte_idx_n = byte_idx;
        hi_phase_n = hi_phase;
        shift_n    = shift_q;
        crc_n      = crc_q;
        nib_n      = nib_q;
        ifg_n      = ifg_q;
        tx_d_n     = tx_d_q;
        tx_en_n    = tx_en_q;
        busy_n     = busy_q;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                addr_n  = '0;
                tx_d_n  = '0;
                tx_en_n = 1'b0;
                if (bus.start) begin
                    state_n = FETCH;
                    crc_n   = CRC_INIT;
                    busy_n  = 1'b1;
                end
            end

            FETCH: begin
                shift_n    = bus.din;
                tx_d_n     = bus.din[3:0];
                tx_en_n    = 1'b1;
                byte_idx_n = '0;
                hi_phase_n = 1'b0;
                addr_n     = 11'd1;
                if (PREAMBLE_LEN == 0) begin
                    crc_n = crc_nibble(crc_q, bus.din[3:0]);
                end
                state_n = DATA;
            end

            DATA: begin
                if (!hi_phase) begin
                    tx_d_n     = shift_q[7:4];
                    hi_phase_n = 1'b1;
                    if (byte_idx >= FIRST_CRC) begin
                        crc_n = crc_nibble(crc_q, shift_q[7:4]);
                    end
                end else if (byte_idx == LAST_BYTE) begin
                    state_n = FCS;
                    tx_d_n  = fcs[3:0];
                    nib_n   = '0;
                end else begin
                    byte_idx_n = next_idx;
                    shift_n    = bus.din;
                    tx_d_n     = bus.din[3:0];
                    hi_phase_n = 1'b0;
                    addr_n     = (addr_q == LAST_BYTE) ? addr_q : addr_q + 11'd1;
                    if (next_idx >= FIRST_CRC) begin
                        crc_n = crc_nibble(crc_q, bus.din[3:0]);
                    end
                end
            end

            FCS: begin
                if (nib_q == 3'd7) begin
                    state_n = IFG;
                    tx_en_n = 1'b0;
                    tx_d_n  = '0;
                    ifg_n   = '0;
                    done_n  = (IFG_CYCLES == 1);
                end else begin
                    nib_n  = nib_next;
                    tx_d_n = fcs[{nib_next, 2'b00} +: 4];
                end
            end

            IFG: begin
                if (ifg_q == IFG_LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    addr_n  = '0;
                end else begin
                    ifg_n  = ifg_q + IFG_W'(1);
                    done_n = ((ifg_q + IFG_W'(1)) == IFG_LAST);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            byte_idx <= '0;
            hi_phase <= 1'b0;
            shift_q  <= '0;
            crc_q    <= CRC_INIT;
            nib_q    <= '0;
            ifg_q    <= '0;
            tx_d_q   <= '0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            addr_q   <= addr_n;
            byte_idx <= byte_idx_n;
            hi_phase <= hi_phase_n;
            shift_q  <= shift_n;
            crc_q    <= crc_n;
            nib_q    <= nib_n;
            ifg_q    <= ifg_n;
            tx_d_q   <= tx_d_n;
            tx_en_q  <= tx_en_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.tx_d  = tx_d_q;
    assign bus.tx_en = tx_en_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
